// File: rtl/vfifo_mc_pkg.sv
// Shared definitions for the multi-channel virtual FIFO reader and writer:
// AXI burst/response encodings, pointer width helper and the 4 KiB boundary.
package vfifo_mc_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  localparam int unsigned BOUNDARY_4K = 4096;

  // Beat pointer width; the extra MSB is the wrap bit that separates full from empty.
  function automatic int ptr_width(input int ch_addr_width, input int tdata_bytes);
    return ch_addr_width - $clog2(tdata_bytes) + 1;
  endfunction

endpackage

// File: rtl/vfifo_rd_buf.sv
// First-word-fall-through FIFO holding read beats with a side tag,
// exposing its occupancy so the reader can reserve space before a burst.
module vfifo_rd_buf #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [CNT_W-1:0]  count
);

  logic [TAG_W+DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    push, pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign pop  = rd_en && (cnt_q != '0);
  assign push = wr_en && ((cnt_q != CNT_W'(DEPTH)) || pop);

  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {wr_tag, wr_data};
  end

  assign rd_valid          = (cnt_q != '0);
  assign {rd_tag, rd_data} = mem_q[rptr_q];
  assign count             = cnt_q;

endmodule

// File: rtl/vfifo_mc_axi_reader.sv
// Multi-channel ring-buffer read engine: round-robin burst issue on one AXI4 read port,
// beats returned on one stream tagged by channel. Optional per-channel beat counters: VFIFO_MC_RD_STATS_EN.
module vfifo_mc_axi_reader
  import vfifo_mc_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int TDATA_BYTES   = 8,
  parameter int CH_ADDR_WIDTH = 12,
  parameter int ADDR_WIDTH    = 16,
  parameter int MAX_BURST_LEN = 16,
  localparam int PTR_W        = ptr_width(CH_ADDR_WIDTH, TDATA_BYTES),
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*PTR_W-1:0]  wr_ptr,
  output logic [NUM_CH*PTR_W-1:0]  rd_ptr,
  output logic [NUM_CH-1:0]        rd_err,
  output logic                     mem_arvalid,
  input  logic                     mem_arready,
  output logic [ADDR_WIDTH-1:0]    mem_araddr,
  output logic [7:0]               mem_arlen,
  output logic [2:0]               mem_arsize,
  output logic [1:0]               mem_arburst,
  output logic [3:0]               mem_arid,
  input  logic                     mem_rvalid,
  output logic                     mem_rready,
  input  logic [8*TDATA_BYTES-1:0] mem_rdata,
  input  logic [3:0]               mem_rid,
  input  logic [1:0]               mem_rresp,
  input  logic                     mem_rlast,
  output logic                     initiator_tvalid,
  input  logic                     initiator_tready,
  output logic [8*TDATA_BYTES-1:0] initiator_tdata,
  output logic [CH_W-1:0]          initiator_tdest,
`ifdef VFIFO_MC_RD_STATS_EN
  output logic [NUM_CH*32-1:0]     rd_beats,
`endif
  output logic                     initiator_tlast
);

  localparam int OFF_W                = $clog2(TDATA_BYTES);
  localparam int DEPTH                = 2 * MAX_BURST_LEN;
  localparam int LEN_W                = $clog2(MAX_BURST_LEN + 1);
  localparam int CNT_W                = $clog2(DEPTH + 1);
  localparam int unsigned REGION_BEATS = 2 ** (PTR_W - 1);
  localparam int unsigned MAX_LEN_U   = MAX_BURST_LEN;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d, rr_q, rr_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]      rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]      rd_ptr_d [NUM_CH];
  logic [NUM_CH-1:0]     rd_err_q, rd_err_d;

  logic [PTR_W-1:0]      fill    [NUM_CH];
  logic [ADDR_WIDTH-1:0] ch_addr [NUM_CH];
  logic [LEN_W-1:0]      ch_len  [NUM_CH];
  logic                  found;
  logic [CH_W-1:0]       cand;
  logic [CNT_W-1:0]      buf_count, buf_free;
  logic                  buf_wr, buf_pop;

  // Burst length limited by data present, max burst, ring end and 4 KiB crossing.
  function automatic logic [LEN_W-1:0] calc_len(input logic [PTR_W-1:0] fill_c,
                                                input logic [PTR_W-2:0] off_c,
                                                input logic [11:0]      addr_lo);
    int unsigned n, to_end, to_4k;
    n      = 32'(fill_c);
    to_end = REGION_BEATS - 32'(off_c);
    to_4k  = (BOUNDARY_4K - 32'(addr_lo)) >> OFF_W;
    if (n > MAX_LEN_U) n = MAX_LEN_U;
    if (n > to_end) n = to_end;
    if (n > to_4k) n = to_4k;
    return LEN_W'(n);
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign fill[c]    = wr_ptr[c*PTR_W +: PTR_W] - rd_ptr_q[c];
    assign ch_addr[c] = (ADDR_WIDTH'(c) << CH_ADDR_WIDTH) |
                        (ADDR_WIDTH'(rd_ptr_q[c][PTR_W-2:0]) << OFF_W);
    assign ch_len[c]  = calc_len(fill[c], rd_ptr_q[c][PTR_W-2:0], ch_addr[c][11:0]);
    assign rd_ptr[c*PTR_W +: PTR_W] = rd_ptr_q[c];
  end

  // Search starts one past the last served channel.
  always_comb begin
    found = 1'b0;
    cand  = rr_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && ch_en[(int'(rr_q) + i) % NUM_CH] &&
          (fill[(int'(rr_q) + i) % NUM_CH] != '0)) begin
        found = 1'b1;
        cand  = CH_W'((int'(rr_q) + i) % NUM_CH);
      end
    end
  end

  assign buf_free = CNT_W'(DEPTH) - buf_count;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    len_d       = len_q;
    addr_d      = addr_q;
    rr_d        = rr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_err_d    = rd_err_q;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    buf_wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && (buf_free >= CNT_W'(ch_len[cand]))) begin
          ch_d    = cand;
          len_d   = ch_len[cand];
          addr_d  = ch_addr[cand];
          state_d = ADDR;
        end
      end
      ADDR: begin
        mem_arvalid = 1'b1;
        if (mem_arready) state_d = DATA;
      end
      DATA: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          buf_wr = 1'b1;
          if ((mem_rresp != OKAY) || (mem_rid != 4'(ch_q))) rd_err_d[ch_q] = 1'b1;
          if (mem_rlast) begin
            rd_ptr_d[ch_q] = rd_ptr_q[ch_q] + PTR_W'(len_q);
            rr_d           = ch_q;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      rr_q     <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      rd_err_q <= '0;
      for (int c = 0; c < NUM_CH; c++) rd_ptr_q[c] <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rr_q     <= rr_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      rd_err_q <= rd_err_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rd_err      = rd_err_q;
  assign mem_araddr  = addr_q;
  assign mem_arlen   = 8'(len_q - LEN_W'(1));
  assign mem_arsize  = 3'(OFF_W);
  assign mem_arburst = INCR;
  assign mem_arid    = 4'(ch_q);

  assign buf_pop = initiator_tvalid && initiator_tready;

  vfifo_rd_buf #(
    .DATA_W (8 * TDATA_BYTES),
    .TAG_W  (CH_W + 1),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk      (aclk),
    .rst_n    (aresetn),
    .wr_en    (buf_wr),
    .wr_data  (mem_rdata),
    .wr_tag   ({ch_q, mem_rlast}),
    .rd_en    (initiator_tready),
    .rd_valid (initiator_tvalid),
    .rd_data  (initiator_tdata),
    .rd_tag   ({initiator_tdest, initiator_tlast}),
    .count    (buf_count)
  );

`ifdef VFIFO_MC_RD_STATS_EN
  logic [31:0] beats_q [NUM_CH];
  logic [31:0] beats_d [NUM_CH];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_comb begin
    beats_d = beats_q;
    if (buf_pop) beats_d[initiator_tdest] = sat_inc(beats_q[initiator_tdest]);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CH; c++) beats_q[c] <= '0;
    end else begin
      beats_q <= beats_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_stats
    assign rd_beats[c*32 +: 32] = beats_q[c];
  end
`endif

endmodule
